adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one SIZE-bit adder between four requesters in the MIPS64 datapath (PC increment, branch target, effective address, spare) so a single adder instance serves all of them. Requests are arbitrated round-robin, operands are captured into an issue register, and the registered sum is returned with the winner's tag. The pipeline has two stages and accepts one operation per cycle. A global `hold` freezes it for pipeline stalls.

## Interface
- SIZE, 64, operand/result width in bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  4  request per requester; bit i = requester i
- a_in  in  4*SIZE  operand A; requester i at bits [i*SIZE +: SIZE]
- b_in  in  4*SIZE  operand B; same packing
- hold  in  1  stall: no grant, all registers frozen
- gnt  out  4  one-hot grant (combinational); operands of granted requester captured at next edge
- out_valid  out  1  result present on out/out_tag/out_carry
- out_tag  out  2  index of requester that owns the result
- out  out  SIZE  sum, modulo 2^SIZE
- out_carry  out  1  carry out of bit SIZE-1
- busy  out  1  issue stage or output stage holds a valid operation

## Operation
- Priority pointer ptr (2 bits) names the highest-priority requester. Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- gnt = one-hot of the first set req bit in search order. gnt = 0 if hold=1 or req=0.
- Accept edge (gnt[i]=1):
  - issue stage loads a_in[i], b_in[i], tag=i, iv=1.
  - ptr <= i+1 mod 4 (3 wraps to 0).
- No grant and hold=0: iv <= 0; ptr unchanged.
- Output stage, when hold=0:
  - {out_carry,out} <= a_q + b_q, computed as a (SIZE+1)-bit add.
  - out_tag <= tag_q; out_valid <= iv.
  - When iv=0, out, out_carry and out_tag keep their previous values; only out_valid drops.
- hold=1: ptr, issue stage and output stage all keep their values, including out_valid.
- Delivery: a result is consumed exactly once, on the edge where out_valid=1 and hold=0. Consumers qualify with out_valid & ~hold.
- Requester protocol:
  - Hold req and operands stable until gnt[i] is seen.
  - Deassert req, or present the next operation, in the cycle after the grant.
  - A request is never lost or dropped while waiting.
- busy = iv | out_valid.
- Reset (async, any time):
  - ptr=0, iv=0, tag_q=0, a_q=b_q=0.
  - out_valid=0, out=0, out_carry=0, out_tag=0.
  - In-flight operations are discarded; requesters reissue.
- gnt is combinational and is 0 while rst=1.

## Timing
- Latency: an operation granted before edge E0 appears with out_valid=1 in the cycle after E0+1 (2 edges, no hold).
- Throughput: 1 accept per cycle. Back-to-back grants give back-to-back out_valid.
- Fairness: with all four req bits held high, grants rotate 0,1,2,3,0…. Any requester waits at most 3 grants.
- Each cycle of hold=1 extends latency by exactly 1 cycle. No grant is issued during hold.
- Simultaneous grant edge and output edge are independent: the issue and output stages update on the same edge.
- Reset deassertion: the first grant can occur in the first cycle after rst falls.

## Test plan
- Reset then single request:
  - Stimulus: req=0001, a=5, b=7.
  - Response: gnt=0001 in cycle 0. Cycle 2: out_valid=1, out=12, out_tag=0, out_carry=0. Cycle 3: out_valid=0.
- Wrap/carry:
  - Stimulus: req=0100, a=0xFFFF_FFFF_FFFF_FFFF, b=2.
  - Response: out=1, out_carry=1, out_tag=2.
- Round-robin:
  - Stimulus: req=1111 held for 8 cycles, operands a=i, b=10·i.
  - Response: gnt sequence 0001,0010,0100,1000 repeating. Results 0,11,22,33 each tagged correctly, one per cycle.
- Pointer skip:
  - Stimulus: after a grant to 1 (ptr=2), present req=0011.
  - Response: gnt=0001 (requester 0, not 1); then ptr=1.
- Hold:
  - Stimulus: issue an operation, then assert hold for 3 cycles while it sits in the issue stage.
  - Response: gnt=0 throughout the hold; out_valid appears exactly 3 cycles later than without hold. The result is delivered once.
- Async reset mid-flight:
  - Stimulus: assert rst between two edges while iv=1 and out_valid=1.
  - Response: out_valid, out, out_tag, busy and gnt go to 0 immediately, without waiting for a clock edge. After release, req=1000 is granted first-cycle with ptr=0 order.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one SIZE-bit adder between four requesters.
// Two stages: an issue register for the granted operands, then a registered sum with its tag.
module adder_arbiter #(
  parameter int SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [4*SIZE-1:0] a_in,
  input  logic [4*SIZE-1:0] b_in,
  input  logic              hold,
  output logic [3:0]        gnt,
  output logic              out_valid,
  output logic [1:0]        out_tag,
  output logic [SIZE-1:0]   out,
  output logic              out_carry,
  output logic              busy
);

  // Handshake: requester i holds req[i] and its operands until it sees gnt[i];
  // the operands are captured on that edge. A result is consumed exactly once,
  // on an edge where out_valid=1 and hold=0; hold freezes every register.

  logic [1:0]      ptr_q, ptr_d;
  logic            iv_q, iv_d;
  logic [1:0]      tag_q, tag_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      out_tag_q, out_tag_d;
  logic [SIZE:0]   res_q, res_d;

  logic            win;
  logic [1:0]      win_idx;
  logic [1:0]      idx;
  logic [SIZE:0]   sum;

  // Search from ptr upward; the first pending request wins.
  always_comb begin
    win     = 1'b0;
    win_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win && req[idx]) begin
        win     = 1'b1;
        win_idx = idx;
      end
    end
    if (rst || hold) win = 1'b0;
  end

  assign gnt = win ? (4'b0001 << win_idx) : 4'b0000;
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    ptr_d       = ptr_q;
    iv_d        = iv_q;
    tag_d       = tag_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    res_d       = res_q;
    if (!hold) begin
      iv_d = win;
      if (win) begin
        ptr_d = win_idx + 2'd1;
        tag_d = win_idx;
        a_d   = a_in[win_idx*SIZE +: SIZE];
        b_d   = b_in[win_idx*SIZE +: SIZE];
      end
      // An empty issue slot only drops out_valid; the last result stays visible.
      out_valid_d = iv_q;
      if (iv_q) begin
        res_d     = sum;
        out_tag_d = tag_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      iv_q        <= 1'b0;
      tag_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= 2'd0;
      res_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      iv_q        <= iv_d;
      tag_q       <= tag_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out       = res_q[SIZE-1:0];
  assign out_carry = res_q[SIZE];
  assign busy      = iv_q | out_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: stimulus pushes hand-computed results,
// a negedge monitor pops and compares each delivered result.
module tb_adder_arbiter;
  localparam int SIZE = 64;
  localparam int W    = SIZE + 3;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [4*SIZE-1:0] a_in;
  logic [4*SIZE-1:0] b_in;
  logic              hold;
  logic [3:0]        gnt;
  logic              out_valid;
  logic [1:0]        out_tag;
  logic [SIZE-1:0]   out;
  logic              out_carry;
  logic              busy;

  logic [SIZE-1:0] a_arr [4];
  logic [SIZE-1:0] b_arr [4];
  logic [W-1:0]    exp_q [$];
  logic [SIZE-1:0] rr_sum [4];
  int              n_tests;
  int              n_fail;

  assign a_in = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign b_in = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  adder_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .hold(hold),
    .gnt(gnt), .out_valid(out_valid), .out_tag(out_tag), .out(out),
    .out_carry(out_carry), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish (got running, required done)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] tag, input logic carry, input logic [SIZE-1:0] s);
    exp_q.push_back({tag, carry, s});
  endtask

  // scoreboard monitor: one pop per delivered result
  always @(negedge clk) begin
    if (!rst && out_valid && !hold) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got tag=%0d sum=%0h, required none", out_tag, out);
      end else begin
        check("result", {out_tag, out_carry, out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rr_sum[0] = 64'd0; rr_sum[1] = 64'd11; rr_sum[2] = 64'd22; rr_sum[3] = 64'd33;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    rst  = 1'b1;
    hold = 1'b0;
    req  = 4'b1111;
    tick();
    tick();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 64'd0);
    check("rst_out_tag", out_tag, 2'd0);
    check("rst_out_carry", out_carry, 1'b0);
    check("rst_busy", busy, 1'b0);

    // single request right after reset release
    rst = 1'b0;
    a_arr[0] = 64'd5; b_arr[0] = 64'd7; req = 4'b0001; #1;
    check("single_gnt", gnt, 4'b0001);
    push(2'd0, 1'b0, 64'd12);
    tick(); req = 4'b0000; #1;
    check("single_c1_valid", out_valid, 1'b0);
    check("single_c1_busy", busy, 1'b1);
    tick();
    check("single_c2_valid", out_valid, 1'b1);
    tick();
    check("single_c3_valid", out_valid, 1'b0);

    // pointer skip (ptr=1 here)
    a_arr[1] = 64'd1; b_arr[1] = 64'd2; req = 4'b0010; #1;
    check("skip_a_gnt", gnt, 4'b0010);
    push(2'd1, 1'b0, 64'd3);
    tick();
    a_arr[0] = 64'd4; b_arr[0] = 64'd4; a_arr[1] = 64'd6; b_arr[1] = 64'd7; req = 4'b0011; #1;
    check("skip_b_gnt", gnt, 4'b0001);
    push(2'd0, 1'b0, 64'd8);
    tick();
    a_arr[0] = 64'd100; b_arr[0] = 64'd200; req = 4'b0011; #1;
    check("skip_c_gnt", gnt, 4'b0010);
    push(2'd1, 1'b0, 64'd13);
    tick();
    req = 4'b0001; #1;
    check("skip_d_gnt", gnt, 4'b0001);
    push(2'd0, 1'b0, 64'd300);
    tick(); req = 4'b0000;
    tick(); tick(); tick();

    // wrap / carry
    a_arr[2] = 64'hFFFF_FFFF_FFFF_FFFF; b_arr[2] = 64'd2; req = 4'b0100; #1;
    check("wrap_gnt", gnt, 4'b0100);
    push(2'd2, 1'b1, 64'd1);
    tick(); req = 4'b0000;
    tick(); tick();

    // hold while the operation sits in the issue stage (ptr=3)
    a_arr[3] = 64'd10; b_arr[3] = 64'd20; req = 4'b1000; #1;
    check("hold_gnt", gnt, 4'b1000);
    push(2'd3, 1'b0, 64'd30);
    tick();
    for (int c = 0; c < 3; c++) begin
      hold = 1'b1; req = 4'b1111; #1;
      check("hold_gnt_zero", gnt, 4'b0000);
      check("hold_no_valid", out_valid, 1'b0);
      check("hold_busy", busy, 1'b1);
      tick();
    end
    hold = 1'b0; req = 4'b0000; #1;
    check("hold_c4_valid", out_valid, 1'b0);
    tick();
    check("hold_c5_valid", out_valid, 1'b1);
    hold = 1'b1;
    tick();
    hold = 1'b0; #1;
    check("hold_c6_valid_kept", out_valid, 1'b1);
    tick();
    check("hold_c7_valid", out_valid, 1'b0);

    // round robin with all four requesting (ptr=0)
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 64'(i);
      b_arr[i] = 64'(10 * i);
    end
    for (int k = 0; k < 10; k++) begin
      req = (k < 8) ? 4'b1111 : 4'b0000; #1;
      check("rr_gnt", gnt, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
      if (k < 8) push(2'(k % 4), 1'b0, rr_sum[k % 4]);
      check("rr_valid", out_valid, (k >= 2) ? 1'b1 : 1'b0);
      tick();
    end
    check("rr_end_valid", out_valid, 1'b0);

    // async reset with both stages occupied (ptr=0)
    a_arr[3] = 64'd1; b_arr[3] = 64'd1; req = 4'b1000; #1;
    check("ar_gnt3", gnt, 4'b1000);
    push(2'd3, 1'b0, 64'd2);
    tick();
    a_arr[2] = 64'd5; b_arr[2] = 64'd6; req = 4'b0100; #1;
    check("ar_gnt2", gnt, 4'b0100);
    push(2'd2, 1'b0, 64'd11);
    tick();
    check("ar_pre_valid", out_valid, 1'b1);
    check("ar_pre_tag", out_tag, 2'd3);
    req = 4'b0010; rst = 1'b1; #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_out", out, 64'd0);
    check("ar_tag", out_tag, 2'd0);
    check("ar_busy", busy, 1'b0);
    check("ar_gnt", gnt, 4'b0000);
    exp_q.delete();
    tick();
    rst = 1'b0;
    a_arr[1] = 64'd20; b_arr[1] = 64'd22; a_arr[3] = 64'd3; b_arr[3] = 64'd4; req = 4'b1010; #1;
    check("ar_first_gnt", gnt, 4'b0010);
    push(2'd1, 1'b0, 64'd42);
    tick();
    req = 4'b1000; #1;
    check("ar_second_gnt", gnt, 4'b1000);
    push(2'd3, 1'b0, 64'd7);
    tick(); req = 4'b0000;

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    tick();
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
